ll_control_n: RTL and testbench

- Parametrised next-generation lunar-lander control unit; replaces the fixed 4-digit control block.
- Sits between ll_memory and the display/LED logic.
- Owns the simulation-step prescaler, the run/pause/landed/crashed state machine, the memory write-enable pulse, touchdown classification and a BCD step counter.
- Width, crash threshold and step rate are parametrised.

---
 rtl/ll_pkg.sv | 49 ++++
 rtl/ll_bcdaddn.sv | 35 +++
 rtl/ll_control_n.sv | 143 ++++++++++++++
 tb/tb_ll_control_n.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// ----------------------------------------------------------------------------
// ll_pkg : shared types and BCD helpers for the lunar-lander control slice
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ll_pkg;

    typedef enum logic [1:0] {IDLE, RUN, LANDED, CRASHED} ll_state_t;

    localparam int MAX_DIGITS = 16;

    // A ten's-complement BCD value is negative when its top digit is 5..9.
    function automatic logic bcd_is_neg(input logic [4*MAX_DIGITS-1:0] value,
                                        input int digits);
        logic [3:0] top;
        top = value[4*digits-1 -: 4];
        return (top >= 4'd5);
    endfunction

    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input longint unsigned n,
                                                      input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        longint unsigned         v;
        r = '0;
        v = n;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(v % 64'd10);
                v           = v / 64'd10;
            end
        end
        return r;
    endfunction

    // BCD encoding of -crash_vel, i.e. 10^digits - crash_vel.
    function automatic logic [4*MAX_DIGITS-1:0] crash_limit_bcd(input int digits,
                                                               input int crash_vel);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return to_bcd(p - longint'(unsigned'(crash_vel)), digits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ll_bcdaddn.sv
// ----------------------------------------------------------------------------
// ll_bcdaddn : N-digit ripple BCD adder built from per-digit add-and-correct slices
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ll_bcdaddn #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                ci,
    output logic [4*DIGITS-1:0] s,
    output logic                co
);

    logic [DIGITS:0] c;

    assign c[0] = ci;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [4:0] raw;
        logic       adj;

        assign raw           = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + {4'd0, c[g]};
        assign adj           = (raw > 5'd9);
        assign s[4*g +: 4]   = adj ? 4'(raw + 5'd6) : raw[3:0];
        assign c[g+1]        = adj;
    end

    assign co = c[DIGITS];

endmodule

`default_nettype wire

// File: rtl/ll_control_n.sv
// ----------------------------------------------------------------------------
// ll_control_n : step prescaler, run/pause/landed/crashed FSM, touchdown check, BCD step counter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ll_control_n
    import ll_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 25,
    parameter int CRASH_VEL = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                hold,
    input  logic [4*DIGITS-1:0] alt,
    input  logic [4*DIGITS-1:0] vel,
    output logic                wen,
    output logic                land,
    output logic                crash,
    output logic                running,
    output logic [4*DIGITS-1:0] steps
);

    localparam int            W         = 4*DIGITS;
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV-1);
    localparam logic [W-1:0]  CRASH_LIM = W'(crash_limit_bcd(DIGITS, CRASH_VEL));

    ll_state_t     state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  steps_q, steps_d;
    logic          wen_q, wen_d;
    logic          land_q, land_d;
    logic          crash_q, crash_d;
    logic          run_q, run_d;

    logic [W-1:0]  sum;
    logic [W-1:0]  steps_inc;
    logic          unused_sum_co;
    logic          unused_inc_co;
    logic          step;
    logic          touchdown;
    logic          safe;

    ll_bcdaddn #(.DIGITS(DIGITS)) u_sum (
        .a  (alt),
        .b  (vel),
        .ci (1'b0),
        .s  (sum),
        .co (unused_sum_co)
    );

    ll_bcdaddn #(.DIGITS(DIGITS)) u_inc (
        .a  (steps_q),
        .b  ('0),
        .ci (1'b1),
        .s  (steps_inc),
        .co (unused_inc_co)
    );

    // hold has priority over the wrap, so a held prescaler sits at PRE_LAST.
    assign step      = (state_q == RUN) && !hold && (pre_q == PRE_LAST);
    assign touchdown = (sum == '0) || bcd_is_neg((4*MAX_DIGITS)'(sum), DIGITS);
    assign safe      = !bcd_is_neg((4*MAX_DIGITS)'(vel), DIGITS) || (vel >= CRASH_LIM);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        steps_d = steps_q;
        wen_d   = 1'b0;
        land_d  = land_q;
        crash_d = crash_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (step) begin
                    pre_d   = '0;
                    wen_d   = 1'b1;
                    steps_d = steps_inc;
                    if (touchdown) begin
                        if (safe) begin
                            state_d = LANDED;
                            land_d  = 1'b1;
                        end else begin
                            state_d = CRASHED;
                            crash_d = 1'b1;
                        end
                    end
                end else if (!hold) begin
                    pre_d = pre_q + 1'b1;
                end
            end
            LANDED, CRASHED: begin
                if (go) begin
                    state_d = RUN;
                    pre_d   = '0;
                    steps_d = '0;
                    land_d  = 1'b0;
                    crash_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        run_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            steps_q <= '0;
            wen_q   <= 1'b0;
            land_q  <= 1'b0;
            crash_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            steps_q <= steps_d;
            wen_q   <= wen_d;
            land_q  <= land_d;
            crash_q <= crash_d;
            run_q   <= run_d;
        end
    end

    assign wen     = wen_q;
    assign land    = land_q;
    assign crash   = crash_q;
    assign running = run_q;
    assign steps   = steps_q;

endmodule

`default_nettype wire

// File: tb/tb_ll_control_n.sv
// ----------------------------------------------------------------------------
// tb_ll_control_n : directed self-checking bench for ll_control_n
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ll_control_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        rst_c = 1'b0;
    logic        go_a = 1'b0, hold_a = 1'b0;
    logic        go_b = 1'b0, hold_b = 1'b0;
    logic        go_c = 1'b0, hold_c = 1'b0;
    logic [15:0] alt_a, vel_a, steps_a, alt_b, vel_b, steps_b;
    logic [23:0] alt_c, vel_c, steps_c;
    logic        wen_a, land_a, crash_a, run_a;
    logic        wen_b, land_b, crash_b, run_b;
    logic        wen_c, land_c, crash_c, run_c;

    int n_cmp = 0;
    int n_bad = 0;

    ll_control_n #(.DIGITS(4), .TICK_DIV(4), .CRASH_VEL(30)) u_a (
        .clk(clk), .rst(rst_n), .go(go_a), .hold(hold_a), .alt(alt_a), .vel(vel_a),
        .wen(wen_a), .land(land_a), .crash(crash_a), .running(run_a), .steps(steps_a));

    ll_control_n #(.DIGITS(4), .TICK_DIV(2), .CRASH_VEL(30)) u_b (
        .clk(clk), .rst(rst_n), .go(go_b), .hold(hold_b), .alt(alt_b), .vel(vel_b),
        .wen(wen_b), .land(land_b), .crash(crash_b), .running(run_b), .steps(steps_b));

    ll_control_n #(.DIGITS(6), .TICK_DIV(25), .CRASH_VEL(30)) u_c (
        .clk(clk), .rst(rst_c), .go(go_c), .hold(hold_c), .alt(alt_c), .vel(vel_c),
        .wen(wen_c), .land(land_c), .crash(crash_c), .running(run_c), .steps(steps_c));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nw;
        alt_a = 16'h4500; vel_a = 16'h0000;
        alt_b = 16'h4500; vel_b = 16'h0000;
        alt_c = 24'h000010; vel_c = 24'h999960;
        tick(3);
        check_eq("rst_wen",   32'(wen_a),   0);
        check_eq("rst_land",  32'(land_a),  0);
        check_eq("rst_crash", 32'(crash_a), 0);
        check_eq("rst_run",   32'(run_a),   0);
        check_eq("rst_steps", 32'(steps_a), 0);
        rst_n = 1'b1; rst_c = 1'b1;
        nw = 0;
        repeat (5) begin tick(1); if (wen_a) nw++; end
        check_eq("idle_no_wen", nw, 0);

        // Free run: wen every 4th cycle, first one 4 edges after the go edge
        go_a = 1'b1; tick(1); go_a = 1'b0;
        check_eq("go_run", 32'(run_a), 1);
        for (int p = 1; p <= 3; p++) begin
            for (int c = 0; c < 3; c++) begin tick(1); check_eq("period_quiet", 32'(wen_a), 0); end
            tick(1);
            check_eq("period_wen", 32'(wen_a), 1);
            check_eq("period_steps", 32'(steps_a), p);
        end

        // Hold mid-period: resume from the frozen count
        tick(1);
        hold_a = 1'b1;
        for (int c = 0; c < 10; c++) begin tick(1); check_eq("hold_quiet", 32'(wen_a), 0); end
        hold_a = 1'b0;
        tick(1); check_eq("resume_q1", 32'(wen_a), 0);
        tick(1); check_eq("resume_q2", 32'(wen_a), 0);
        tick(1); check_eq("resume_wen", 32'(wen_a), 1);
        check_eq("resume_steps", 32'(steps_a), 32'h4);

        // Hold raised on the wrap cycle: step fires on the first unheld cycle
        for (int c = 0; c < 3; c++) begin tick(1); check_eq("prewrap_quiet", 32'(wen_a), 0); end
        hold_a = 1'b1;
        nw = 0;
        repeat (5) begin tick(1); if (wen_a) nw++; end
        check_eq("wrap_hold_no_wen", nw, 0);
        hold_a = 1'b0;
        tick(1);
        check_eq("wrap_release_wen", 32'(wen_a), 1);
        check_eq("wrap_release_steps", 32'(steps_a), 32'h5);

        // go during RUN must not restart the prescaler
        tick(1); go_a = 1'b1; tick(1); go_a = 1'b0;
        tick(1); check_eq("go_in_run_quiet", 32'(wen_a), 0);
        tick(1); check_eq("go_in_run_wen", 32'(wen_a), 1);
        check_eq("go_in_run_steps", 32'(steps_a), 32'h6);

        // Safe touchdown: 0020 + 9980 = 0000, vel -20 within limit
        alt_a = 16'h0020; vel_a = 16'h9980;
        tick(3);
        check_eq("land_pre_quiet", 32'(wen_a), 0);
        tick(1);
        check_eq("land_wen",   32'(wen_a),   1);
        check_eq("land_land",  32'(land_a),  1);
        check_eq("land_crash", 32'(crash_a), 0);
        check_eq("land_run",   32'(run_a),   0);
        check_eq("land_steps", 32'(steps_a), 32'h7);
        nw = 0;
        repeat (20) begin tick(1); if (wen_a) nw++; end
        check_eq("landed_no_wen", nw, 0);
        check_eq("landed_sticky", 32'(land_a), 1);

        // Crash: 0020 + 9950 = 9970 negative, vel -50 beyond limit
        vel_a = 16'h9950;
        go_a = 1'b1; tick(1); go_a = 1'b0;
        check_eq("rego_run",   32'(run_a),   1);
        check_eq("rego_land",  32'(land_a),  0);
        check_eq("rego_steps", 32'(steps_a), 0);
        tick(4);
        check_eq("crash_wen",   32'(wen_a),   1);
        check_eq("crash_crash", 32'(crash_a), 1);
        check_eq("crash_land",  32'(land_a),  0);
        check_eq("crash_steps", 32'(steps_a), 32'h1);
        alt_a = 16'h4500; vel_a = 16'h0000;
        go_a = 1'b1; tick(1); go_a = 1'b0;
        check_eq("recover_run",   32'(run_a),   1);
        check_eq("recover_crash", 32'(crash_a), 0);
        check_eq("recover_steps", 32'(steps_a), 0);

        // Asynchronous reset while wen is high
        tick(4);
        check_eq("pre_rst_wen", 32'(wen_a), 1);
        rst_n = 1'b0; #1;
        check_eq("async_rst_wen",   32'(wen_a),   0);
        check_eq("async_rst_run",   32'(run_a),   0);
        check_eq("async_rst_steps", 32'(steps_a), 0);
        tick(1); rst_n = 1'b1;

        // Step counter wraps 9999 -> 0000
        go_b = 1'b1; tick(1); go_b = 1'b0;
        for (int k = 0; k < 25000 && steps_b !== 16'h9999; k++) tick(1);
        check_eq("b_reach_9999", 32'(steps_b), 32'h9999);
        tick(2);
        check_eq("b_wrap_wen",   32'(wen_b),   1);
        check_eq("b_wrap_steps", 32'(steps_b), 0);

        // Six digits: reset with prescaler at 10, then crash with vel -40
        go_c = 1'b1; tick(1); go_c = 1'b0;
        tick(10);
        #2; rst_c = 1'b0; #1;
        check_eq("c_rst_run",   32'(run_c),   0);
        check_eq("c_rst_wen",   32'(wen_c),   0);
        check_eq("c_rst_steps", 32'(steps_c), 0);
        check_eq("c_rst_flags", 32'({land_c, crash_c}), 0);
        @(posedge clk); #1; rst_c = 1'b1;
        nw = 0;
        repeat (30) begin tick(1); if (wen_c) nw++; end
        check_eq("c_idle_no_wen", nw, 0);
        go_c = 1'b1; tick(1); go_c = 1'b0;
        nw = 0;
        repeat (24) begin tick(1); if (wen_c) nw++; end
        check_eq("c_period_quiet", nw, 0);
        tick(1);
        check_eq("c_crash_wen",   32'(wen_c),   1);
        check_eq("c_crash_crash", 32'(crash_c), 1);
        check_eq("c_crash_land",  32'(land_c),  0);
        check_eq("c_crash_steps", 32'(steps_c), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
